mem_bus_arbiter: RTL

MEM_BUS_ARBITER -- requirements
Module: mem_bus_arbiter

---
 rtl/mem_bus_arbiter_if.sv | 32 +++
 rtl/mem_bus_arbiter.sv | 97 +++++++++
 2 files changed

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: fetch/memory request ports and sram-like bus of the arbiter
// MEM_ARB_ALIGN_CHECK_EN adds the inst_err/data_err alignment-error outputs.
interface mem_bus_arbiter_if;
  logic        inst_req, inst_ready;
  logic [31:0] inst_addr, inst_rdata;
  logic        data_req, data_wr, data_ready;
  logic [1:0]  data_mode;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok;
  logic [1:0]  bus_size;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic        inst_err, data_err;
  modport master (output inst_req, inst_addr, data_req, data_wr, data_mode, data_addr, data_wdata,
                  bus_addr_ok, bus_data_ok, bus_rdata,
                  input inst_ready, inst_rdata, data_ready, data_rdata, bus_req, bus_wr, bus_size,
                  bus_addr, bus_wdata, inst_err, data_err);
  modport slave (input inst_req, inst_addr, data_req, data_wr, data_mode, data_addr, data_wdata,
                 bus_addr_ok, bus_data_ok, bus_rdata,
                 output inst_ready, inst_rdata, data_ready, data_rdata, bus_req, bus_wr, bus_size,
                 bus_addr, bus_wdata, inst_err, data_err);
`else
  modport master (output inst_req, inst_addr, data_req, data_wr, data_mode, data_addr, data_wdata,
                  bus_addr_ok, bus_data_ok, bus_rdata,
                  input inst_ready, inst_rdata, data_ready, data_rdata, bus_req, bus_wr, bus_size,
                  bus_addr, bus_wdata);
  modport slave (input inst_req, inst_addr, data_req, data_wr, data_mode, data_addr, data_wdata,
                 bus_addr_ok, bus_data_ok, bus_rdata,
                 output inst_ready, inst_rdata, data_ready, data_rdata, bus_req, bus_wr, bus_size,
                 bus_addr, bus_wdata);
`endif
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: arbitrates fetch and memory-stage requests onto one sram-like bus
// MEM_ARB_ALIGN_CHECK_EN completes misaligned requests locally with an error pulse.
module mem_bus_arbiter (
  input logic clk,
  input logic reset,
  mem_bus_arbiter_if.slave m
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
  state_t      state_q, state_d;
  logic        gnt_q, gnt_d, last_q, last_d, wr_q, wr_d, pick_data, mis;
  logic [1:0]  size_q, size_d, sel_size;
  logic [31:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sel_addr;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  logic        err_q, err_d;
`endif
  always_comb begin
    pick_data = m.data_req & (~m.inst_req | ~last_q);
    sel_addr  = pick_data ? m.data_addr : m.inst_addr;
    sel_size  = !pick_data ? 2'b10 : m.data_mode == 2'b00 ? 2'b00 : m.data_mode == 2'b01 ? 2'b01 : 2'b10;
`ifdef MEM_ARB_ALIGN_CHECK_EN
    mis       = sel_size == 2'b10 ? |sel_addr[1:0] : (sel_size == 2'b01) & sel_addr[0];
    err_d     = err_q;
`else
    mis       = 1'b0;
`endif
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wr_d    = wr_q;
    size_d  = size_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    if (state_q == IDLE && (m.inst_req | m.data_req)) begin
      gnt_d   = pick_data;
      last_d  = pick_data;
      state_d = mis ? DONE : REQ;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_d   = mis;
`endif
      if (mis) rdata_d = 32'h0;
      else begin
        wr_d    = pick_data & m.data_wr;
        size_d  = sel_size;
        addr_d  = sel_addr;
        wdata_d = !pick_data ? 32'h0 : sel_size == 2'b00 ? {4{m.data_wdata[7:0]}} :
                  sel_size == 2'b01 ? {2{m.data_wdata[15:0]}} : m.data_wdata;
      end
    end
    if (state_q == REQ && m.bus_addr_ok) state_d = WAIT;
    if (state_q == WAIT && m.bus_data_ok) begin
      state_d = DONE;
      rdata_d = gnt_q ? m.bus_rdata >> {addr_q[1:0], 3'b000} : m.bus_rdata;
    end
    if (state_q == DONE) state_d = IDLE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 1'b0;
      last_q  <= 1'b0;
      wr_q    <= 1'b0;
      size_q  <= 2'b00;
      addr_q  <= 32'h0;
      wdata_q <= 32'h0;
      rdata_q <= 32'h0;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wr_q    <= wr_d;
      size_q  <= size_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
`ifdef MEM_ARB_ALIGN_CHECK_EN
      err_q   <= err_d;
`endif
    end
  end
  assign m.bus_req    = state_q == REQ;
  assign m.bus_wr     = wr_q;
  assign m.bus_size   = size_q;
  assign m.bus_addr   = addr_q;
  assign m.bus_wdata  = wdata_q;
  assign m.inst_ready = (state_q == DONE) & ~gnt_q;
  assign m.data_ready = (state_q == DONE) & gnt_q;
  assign m.inst_rdata = rdata_q;
  assign m.data_rdata = rdata_q;
`ifdef MEM_ARB_ALIGN_CHECK_EN
  assign m.inst_err   = (state_q == DONE) & ~gnt_q & err_q;
  assign m.data_err   = (state_q == DONE) & gnt_q & err_q;
`endif
endmodule
